mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder_reply_tx.sv | 72 +++++++
 rtl/mem_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: header codes, bus widths, FSM encodings.
// The header is carried on rx_pins[1:0], so NSHIFT must be at least 2.
package mem_responder_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   localparam logic [1:0] HDR_READ_16  = 2'b00;
   localparam logic [1:0] HDR_WRITE_8  = 2'b01;
   localparam logic [1:0] HDR_WRITE_16 = 2'b10;
   localparam logic [1:0] HDR_RESERVED = 2'b11;

   typedef enum logic [2:0] {
      IDLE, HDR, ADDR, WDATA, MEMRD, WAIT, RSTART, RDATA
   } state_e;

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_SHIFT
   } tx_phase_e;

   function automatic int payload_cycles(input int nshift);
      return ADDR_W / nshift;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Pin and memory-side bundle of the memory responder; slave is the responder view.
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int NSHIFT = 2
);
   logic [NSHIFT-1:0] rx_pins;
   logic [NSHIFT-1:0] tx_pins;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [1:0]        mem_be;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              proto_err;

   modport slave (
      input  rx_pins, mem_rdata,
      output tx_pins, mem_addr, mem_wdata, mem_we, mem_be, mem_re, busy, proto_err
   );

   modport master (
      output rx_pins, mem_rdata,
      input  tx_pins, mem_addr, mem_wdata, mem_we, mem_be, mem_re, busy, proto_err
   );
endinterface

// File: rtl/mem_responder_reply_tx.sv
// Reply serializer: one all-zero start cycle, then din shifted out LSB-first
// (or nothing more when ack_only), then the line returns to all-ones.
module mem_responder_reply_tx
   import mem_responder_pkg::*;
#(
   parameter int NSHIFT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ack_only,
   input  logic [DATA_W-1:0] din,
   output logic [NSHIFT-1:0] tx_pins
);
   localparam int CW = 5;
   localparam logic [CW-1:0] LAST_CNT = CW'(payload_cycles(NSHIFT));

   tx_phase_e         ph_r;
   logic [DATA_W-1:0] sh_r;
   logic [CW-1:0]     cnt_r;
   logic [NSHIFT-1:0] tx_r;

   assign tx_pins = tx_r;

   // Serializer phase, shift register and registered pin drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_r  <= TX_IDLE;
         sh_r  <= '0;
         cnt_r <= '0;
         tx_r  <= '1;
      end else begin
         case (ph_r)
            TX_IDLE: begin
               if (start) begin
                  tx_r <= '0;
                  ph_r <= TX_START;
               end else begin
                  tx_r <= '1;
               end
            end
            TX_START: begin
               if (ack_only) begin
                  tx_r <= '1;
                  ph_r <= TX_IDLE;
               end else begin
                  tx_r  <= din[NSHIFT-1:0];
                  sh_r  <= {NSHIFT'(0), din[DATA_W-1:NSHIFT]};
                  cnt_r <= CW'(1);
                  ph_r  <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (cnt_r == LAST_CNT) begin
                  tx_r  <= '1;
                  cnt_r <= '0;
                  ph_r  <= TX_IDLE;
               end else begin
                  tx_r  <= sh_r[NSHIFT-1:0];
                  sh_r  <= {NSHIFT'(0), sh_r[DATA_W-1:NSHIFT]};
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               tx_r <= '1;
               ph_r <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Serial-pin memory responder: decodes read/write commands from rx_pins and replies on tx_pins.
// Optional macro WRITE_ACK_EN: each completed write answers with a start-bit-only reply frame.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int NSHIFT     = 2,
   parameter int READ_DELAY = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_responder_if.slave  bus
);
   localparam int PC = payload_cycles(NSHIFT);
   localparam int CW = 5;
   localparam logic [CW-1:0] FULL_LAST = CW'(PC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(PC / 2 - 1);
   localparam logic [CW-1:0] RD_LAST   = CW'(READ_DELAY - 1);
`ifdef WRITE_ACK_EN
   localparam bit ACK_EN = 1'b1;
`else
   localparam bit ACK_EN = 1'b0;
`endif

   state_e            state_r, state_nx_s;
   logic [CW-1:0]     cnt_r;
   logic [1:0]        cmd_r;
   logic [ADDR_W-1:0] addr_sh_r, addr_nx_s;
   logic [DATA_W-1:0] data_sh_r, data_nx_s, rdata_r;
   logic              cap_r, rx0_q_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [1:0]        mem_be_r;
   logic              mem_we_r, mem_re_r;
   logic              is_wr_s, we_s, re_s, perr_s, tx_start_s;
   logic [CW-1:0]     wdata_last_s, wait_last_s;
   logic [NSHIFT-1:0] tx_s;

   assign is_wr_s      = (cmd_r != HDR_READ_16);
   assign wdata_last_s = (cmd_r == HDR_WRITE_8) ? HALF_LAST : FULL_LAST;
   assign wait_last_s  = is_wr_s ? CW'(0) : RD_LAST;
   assign addr_nx_s    = {bus.rx_pins, addr_sh_r[ADDR_W-1:NSHIFT]};
   assign data_nx_s    = {bus.rx_pins, data_sh_r[DATA_W-1:NSHIFT]};
   assign we_s         = (state_r == WDATA) && (cnt_r == wdata_last_s);
   assign re_s         = (state_r == ADDR) && (cnt_r == FULL_LAST) && !is_wr_s;
   assign tx_start_s   = (state_nx_s == RSTART) && (state_r != RSTART);

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_re    = mem_re_r;
   assign bus.busy      = (state_r != IDLE);
   assign bus.proto_err = perr_s;
   assign bus.tx_pins   = tx_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nx_s;
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE:   state_nx_s = bus.rx_pins[0] ? IDLE : HDR;
         HDR:    state_nx_s = (bus.rx_pins[1:0] == HDR_RESERVED) ? IDLE : ADDR;
         ADDR: begin
            if (cnt_r == FULL_LAST) state_nx_s = is_wr_s ? WDATA : MEMRD;
            else                    state_nx_s = ADDR;
         end
         WDATA: begin
            if (cnt_r == wdata_last_s) state_nx_s = ACK_EN ? WAIT : IDLE;
            else                       state_nx_s = WDATA;
         end
         MEMRD:  state_nx_s = (READ_DELAY == 0) ? RSTART : WAIT;
         WAIT:   state_nx_s = (cnt_r == wait_last_s) ? RSTART : WAIT;
         RSTART: state_nx_s = is_wr_s ? IDLE : RDATA;
         RDATA:  state_nx_s = (cnt_r == FULL_LAST) ? IDLE : RDATA;
         default: state_nx_s = IDLE;
      endcase
   end

   // A reserved header, or a fresh start bit while a reply is pending, is a violation.
   always_comb begin
      perr_s = 1'b0;
      if (state_r == HDR) begin
         perr_s = (bus.rx_pins[1:0] == HDR_RESERVED);
      end else if (state_r == WAIT || state_r == RSTART || state_r == RDATA) begin
         perr_s = !bus.rx_pins[0] && rx0_q_r;
      end else begin
         perr_s = 1'b0;
      end
   end

   // Shared shift counter, cleared on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (state_nx_s != state_r) begin
         cnt_r <= '0;
      end else if (state_r == ADDR || state_r == WDATA || state_r == WAIT || state_r == RDATA) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= '0;
      end
   end

   // Command capture, payload shifting and memory strobes; mem_* only move on a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_r       <= HDR_READ_16;
         addr_sh_r   <= '0;
         data_sh_r   <= '0;
         rdata_r     <= '0;
         cap_r       <= 1'b0;
         rx0_q_r     <= 1'b1;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_be_r    <= 2'b00;
         mem_we_r    <= 1'b0;
         mem_re_r    <= 1'b0;
      end else begin
         rx0_q_r  <= bus.rx_pins[0];
         cap_r    <= (state_r == MEMRD);
         mem_we_r <= we_s;
         mem_re_r <= re_s;
         if (state_r == HDR) cmd_r <= bus.rx_pins[1:0];
         if (state_r == ADDR) addr_sh_r <= addr_nx_s;
         if (state_r == WDATA) data_sh_r <= data_nx_s;
         if (cap_r) rdata_r <= bus.mem_rdata;
         if (re_s) mem_addr_r <= addr_nx_s;
         if (we_s) begin
            mem_addr_r <= addr_sh_r;
            if (cmd_r == HDR_WRITE_8) begin
               mem_wdata_r <= {data_nx_s[DATA_W-1:8], data_nx_s[DATA_W-1:8]};
               mem_be_r    <= addr_sh_r[0] ? 2'b10 : 2'b01;
            end else begin
               mem_wdata_r <= data_nx_s;
               mem_be_r    <= 2'b11;
            end
         end
      end
   end

   // With READ_DELAY of zero the reply loads straight from mem_rdata.
   mem_responder_reply_tx #(.NSHIFT(NSHIFT)) u_reply_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tx_start_s),
      .ack_only (is_wr_s),
      .din      (cap_r ? bus.mem_rdata : rdata_r),
      .tx_pins  (tx_s)
   );

endmodule
